mul_div_unit: RTL and testbench

- Iterative 64-bit multiply/divide execution unit for the LEGv8 datapath, directly downstream of the register file.
- Consumes the two register-read operands (DATA_OUT_A/DATA_OUT_B) plus a destination register index.
- Produces a single-cycle write-back pulse whose outputs map onto the register file's WRITE_DATA, WRITE_REG and REG_WRITE_ENABLE.
- Implements MUL, UMULH, UDIV and SDIV with a radix-2 shift-add / restoring-divide datapath, one bit per cycle.

---
 rtl/mul_div_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 64-bit MUL/UMULH/UDIV/SDIV unit for the LEGv8 write-back path
//
// Ports:
//   CLK, RESET                 clock; synchronous active-high reset
//   START, OP, OPERAND_A/B     request; OP 00 MUL, 01 UMULH, 10 UDIV, 11 SDIV
//   DEST_REG                   destination register, echoed on RESULT_REG
//   BUSY                       high whenever the unit is not idle
//   RESULT, RESULT_REG         result and register index, held until next completion
//   RESULT_VALID               one-cycle write-enable pulse
//
// Optional feature macro: MDU_EARLY_OUT_EN
//   When defined, a zero operand completes in one cycle with RESULT=0.
//   When undefined, every operation takes WIDTH+1 cycles.

module mul_div_unit #(
    parameter int WIDTH      = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [1:0]            OP,
    input  logic [WIDTH-1:0]      OPERAND_A,
    input  logic [WIDTH-1:0]      OPERAND_B,
    input  logic [REG_ADDR_W-1:0] DEST_REG,
    output logic                  BUSY,
    output logic [WIDTH-1:0]      RESULT,
    output logic [REG_ADDR_W-1:0] RESULT_REG,
    output logic                  RESULT_VALID
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULH = 2'b01;
    localparam logic [1:0] OP_UDIV  = 2'b10;
    localparam logic [1:0] OP_SDIV  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              op_q, op_d;
    // Multiplicand for MUL/UMULH, divisor magnitude for UDIV/SDIV.
    logic [WIDTH-1:0]        opnd_q, opnd_d;
    // Shared 2*WIDTH working register.
    //   multiply: {partial product high, multiplier bits still to consume}
    //   divide:   {partial remainder, dividend bits shifting out / quotient bits shifting in}
    logic [2*WIDTH-1:0]      p_q, p_d;
    logic                    neg_q, neg_d;
    logic                    dz_q, dz_d;
    logic [REG_ADDR_W-1:0]   dest_q, dest_d;
    logic [WIDTH-1:0]        result_q, result_d;
    logic [REG_ADDR_W-1:0]   result_reg_q, result_reg_d;
    logic                    result_valid_q, result_valid_d;

    // Operand magnitudes for signed division
    logic [WIDTH-1:0]        a_abs, b_abs;

    // One shift-add multiply step
    logic [WIDTH:0]          mul_sum;
    logic [2*WIDTH-1:0]      mul_next;

    // One restoring-divide step
    logic [WIDTH:0]          div_shift;
    logic                    div_ge;
    logic [WIDTH-1:0]        div_diff;
    logic [2*WIDTH-1:0]      div_next;

    logic [2*WIDTH-1:0]      p_next;
    logic [WIDTH-1:0]        quot;
    logic [WIDTH-1:0]        final_result;

    always_comb begin
        a_abs = OPERAND_A[WIDTH-1] ? -OPERAND_A : OPERAND_A;
        b_abs = OPERAND_B[WIDTH-1] ? -OPERAND_B : OPERAND_B;

        // Multiply: add multiplicand into the high half when the current
        // multiplier bit (LSB) is set, then shift the whole register right.
        // The carry out of the add becomes the new MSB.
        mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, p_q[WIDTH-1:1]};

        // Divide: shift the next dividend bit into the remainder and
        // subtract the divisor if it fits. The remainder is always below
        // the divisor afterwards, so a WIDTH-bit subtract is exact.
        div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), p_q[WIDTH-2:0], div_ge};

        p_next = op_q[1] ? div_next : mul_next;
        quot   = p_next[WIDTH-1:0];

        // Result as it will be registered on the last iteration edge.
        // Quotient negation wraps, so MIN / -1 returns MIN.
        case (op_q)
            OP_MUL:   final_result = p_next[WIDTH-1:0];
            OP_UMULH: final_result = p_next[2*WIDTH-1:WIDTH];
            OP_UDIV:  final_result = dz_q ? '0 : quot;
            OP_SDIV:  final_result = dz_q ? '0 : (neg_q ? -quot : quot);
            default:  final_result = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        opnd_d         = opnd_q;
        p_d            = p_q;
        neg_d          = neg_q;
        dz_d           = dz_q;
        dest_d         = dest_q;
        result_d       = result_q;
        result_reg_d   = result_reg_q;
        result_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    op_d    = OP;
                    dest_d  = DEST_REG;
                    if (OP[1]) begin
                        opnd_d = (OP == OP_SDIV) ? b_abs : OPERAND_B;
                        p_d    = {{WIDTH{1'b0}}, ((OP == OP_SDIV) ? a_abs : OPERAND_A)};
                        neg_d  = (OP == OP_SDIV) && (OPERAND_A[WIDTH-1] ^ OPERAND_B[WIDTH-1]);
                        dz_d   = (OPERAND_B == '0);
                    end else begin
                        opnd_d = OPERAND_A;
                        p_d    = {{WIDTH{1'b0}}, OPERAND_B};
                        neg_d  = 1'b0;
                        dz_d   = 1'b0;
                    end
`ifdef MDU_EARLY_OUT_EN
                    // Any zero operand gives zero for every op (0/x, x/0, 0*x),
                    // so skip the iterations entirely.
                    if ((OPERAND_A == '0) || (OPERAND_B == '0)) begin
                        state_d        = S_DONE;
                        result_d       = '0;
                        result_reg_d   = DEST_REG;
                        result_valid_d = 1'b1;
                    end
`endif
                end
            end

            S_CALC: begin
                p_d   = p_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d        = S_DONE;
                    cnt_d          = '0;
                    result_d       = final_result;
                    result_reg_d   = dest_q;
                    result_valid_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            op_q           <= '0;
            opnd_q         <= '0;
            p_q            <= '0;
            neg_q          <= 1'b0;
            dz_q           <= 1'b0;
            dest_q         <= '0;
            result_q       <= '0;
            result_reg_q   <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            opnd_q         <= opnd_d;
            p_q            <= p_d;
            neg_q          <= neg_d;
            dz_q           <= dz_d;
            dest_q         <= dest_d;
            result_q       <= result_d;
            result_reg_q   <= result_reg_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign BUSY         = (state_q != S_IDLE);
    assign RESULT       = result_q;
    assign RESULT_REG   = result_reg_q;
    assign RESULT_VALID = result_valid_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit against an arithmetic reference model

module tb_mul_div_unit;

    localparam int WIDTH      = 64;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULH = 2'b01;
    localparam logic [1:0] OP_UDIV  = 2'b10;
    localparam logic [1:0] OP_SDIV  = 2'b11;

    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL_ONE = 64'hFFFF_FFFF_FFFF_FFFF;

    logic                  CLK = 1'b0;
    logic                  RESET;
    logic                  START;
    logic [1:0]            OP;
    logic [WIDTH-1:0]      OPERAND_A;
    logic [WIDTH-1:0]      OPERAND_B;
    logic [REG_ADDR_W-1:0] DEST_REG;
    logic                  BUSY;
    logic [WIDTH-1:0]      RESULT;
    logic [REG_ADDR_W-1:0] RESULT_REG;
    logic                  RESULT_VALID;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc      = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    mul_div_unit #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .START        (START),
        .OP           (OP),
        .OPERAND_A    (OPERAND_A),
        .OPERAND_B    (OPERAND_B),
        .DEST_REG     (DEST_REG),
        .BUSY         (BUSY),
        .RESULT       (RESULT),
        .RESULT_REG   (RESULT_REG),
        .RESULT_VALID (RESULT_VALID)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0] prod;
        longint       sa, sb, sq;
        prod = {64'd0, a} * {64'd0, b};
        case (op)
            OP_MUL:   return prod[63:0];
            OP_UMULH: return prod[127:64];
            OP_UDIV:  return (b == 0) ? 64'd0 : a / b;
            default: begin
                if (b == 0) return 64'd0;
                if (a == MIN_NEG && b == ALL_ONE) return MIN_NEG;
                sa = a;
                sb = b;
                sq = sa / sb;
                return sq;
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [63:0] a, input logic [63:0] b);
`ifdef MDU_EARLY_OUT_EN
        if (a == 0 || b == 0) return 0;
`endif
        return WIDTH;
    endfunction

    // Drive a request for one edge; t0 is the cycle count just after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] dest, output int unsigned t0);
        START     = 1'b1;
        OP        = op;
        OPERAND_A = a;
        OPERAND_B = b;
        DEST_REG  = dest;
        @(posedge CLK);
        #1;
        START = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!RESULT_VALID && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] dest,
                          input logic [63:0] exp);
        int unsigned t0;
        issue(op, a, b, dest, t0);
        check({tag, "_busy"}, BUSY, 1);
        wait_valid();
        check({tag, "_latency"}, cyc - t0, exp_latency(a, b));
        check({tag, "_result"}, RESULT, exp);
        check({tag, "_reg"}, RESULT_REG, dest);
        @(posedge CLK);
        #1;
        check({tag, "_valid_pulse"}, RESULT_VALID, 0);
        check({tag, "_busy_off"}, BUSY, 0);
        check({tag, "_hold"}, RESULT, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned t0;
        int          seen;
        logic [63:0] ra, rb;
        logic [1:0]  rop;
        logic [4:0]  rd;

        RESET     = 1'b1;
        START     = 1'b0;
        OP        = '0;
        OPERAND_A = '0;
        OPERAND_B = '0;
        DEST_REG  = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", BUSY, 0);
        check("reset_result", RESULT, 0);
        check("reset_reg", RESULT_REG, 0);
        check("reset_valid", RESULT_VALID, 0);
        RESET = 1'b0;

        run_op("mul_small", OP_MUL, 64'hA, 64'h5, 5'd3, 64'h32);
        run_op("mul_wrap", OP_MUL, ALL_ONE, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("umulh", OP_UMULH, ALL_ONE, 64'd2, 5'd5, 64'h1);
        run_op("udiv", OP_UDIV, 64'hA, 64'h5, 5'd6, 64'h2);
        run_op("sdiv_neg", OP_SDIV, -64'sd7, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("sdiv_ovf", OP_SDIV, MIN_NEG, ALL_ONE, 5'd8, MIN_NEG);
        run_op("udiv_zero", OP_UDIV, 64'd10, 64'd0, 5'd9, 64'd0);
        run_op("sdiv_zero", OP_SDIV, -64'sd10, 64'd0, 5'd10, 64'd0);
        run_op("mul_zero", OP_MUL, 64'd0, 64'd7, 5'd11, 64'd0);

        // START during CALC and during DONE ignored; held into IDLE accepted.
        issue(OP_UDIV, 64'd100, 64'd7, 5'd12, t0);
        repeat (10) @(posedge CLK);
        #1;
        START = 1'b1; OP = OP_MUL; OPERAND_A = 64'd5; OPERAND_B = 64'd6; DEST_REG = 5'd13;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_valid();
        check("ign_calc_latency", cyc - t0, WIDTH);
        check("ign_calc_result", RESULT, 64'd14);
        check("ign_calc_reg", RESULT_REG, 5'd12);
        START = 1'b1;
        @(posedge CLK);
        #1;
        check("ign_done_busy", BUSY, 0);
        check("ign_done_valid", RESULT_VALID, 0);
        check("ign_done_hold", RESULT, 64'd14);
        @(posedge CLK);
        #1;
        START = 1'b0;
        t0    = cyc;
        check("held_start_busy", BUSY, 1);
        wait_valid();
        check("held_start_latency", cyc - t0, WIDTH);
        check("held_start_result", RESULT, 64'd30);
        check("held_start_reg", RESULT_REG, 5'd13);
        @(posedge CLK);
        #1;

        // Reset mid-calculation aborts without a write-back.
        issue(OP_MUL, 64'h1234, 64'h5678, 5'd14, t0);
        repeat (30) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("abort_busy", BUSY, 0);
        check("abort_result", RESULT, 0);
        check("abort_reg", RESULT_REG, 0);
        check("abort_valid", RESULT_VALID, 0);
        seen = 0;
        repeat (80) begin
            @(posedge CLK);
            #1;
            if (RESULT_VALID || BUSY) seen = 1;
        end
        check("abort_no_valid", seen, 0);
        run_op("post_abort_mul", OP_MUL, 64'd3, 64'd4, 5'd15, 64'hC);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rb = rb >> $urandom_range(0, 63);
                1: ra = ra >> $urandom_range(0, 63);
                2: if ($urandom_range(0, 3) == 0) rb = 0;
                default: ;
            endcase
            rd = 5'($urandom_range(0, 31));
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, rd, ref_result(rop, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
